gcm_tag_verify: RTL and testbench
=================================

// Module: gcm_tag_verify
// PURPOSE
// - Decrypt-side GCM authentication. Accepts AAD/ciphertext blocks, then the length block (len(A)||len(C)).
// - Accumulates GHASH S = (S ^ X)*H with a digit-serial GF(2^128) multiplier.
// - Forms tag T = S ^ E(K,J0) and compares T against the received tag, reporting pass/fail.
// - Sits after the AES core, which supplies H and E(K,J0); its result gates release of decrypted plaintext.
// PARAMETERS
// - DIGIT  default 1  bits of the multiplier processed per cycle; allowed 1,2,4,8,16. MUL takes NCYC=128/DIGIT cycles.
// PORTS
// - clk             in   1    clock; all logic on posedge.
// - rst             in   1    reset, synchronous, active-high.
// - i_h             in   128  hash subkey H, bit 0 = MSB (GCM order), [0:127]. Latched on i_start.
// - i_encrypted_j0  in   128  E(K,J0). Latched on i_start.
// - i_start         in   1    begin new message; clears S and the tag-seen flag.
// - i_blk_valid     in   1    i_blk valid.
// - i_blk           in   128  AAD or ciphertext block, GCM order, zero-padded by the producer.
// - i_len_valid     in   1    i_len valid.
// - i_len           in   128  len(A)[64] || len(C)[64] in bits.
// - o_blk_ready     out  1    shared ready for i_blk and i_len.
// - i_tag_valid     in   1    i_tag valid.
// - i_tag           in   128  received tag.
// - o_busy          out  1    high in every state except IDLE.
// - o_done          out  1    one-cycle pulse; o_auth_ok and o_tag are valid from this cycle.
// - o_auth_ok       out  1    1 = tag match. Held until next i_start or rst.
// - o_tag           out  128  computed tag. Held until next i_start or rst.
// BEHAVIOUR
// - Reset (rst=1 at posedge): state IDLE; S, H, J0 and tag registers cleared.
//   - All outputs 0 the following cycle. Aborts any operation.
// - FSM states: IDLE, ACC, MUL, FIN, DONE.
// - IDLE: o_blk_ready=0. i_start -> latch H, J0; S=0; tag_seen=0; go to ACC.
// - ACC: o_blk_ready=1.
//   - i_blk_valid: X=S^i_blk; cnt=0; go to MUL with ret=ACC.
//   - else i_len_valid: X=S^i_len; go to MUL with ret=FIN.
//   - Both valid in one cycle: block consumed, length not consumed (it stays pending).
// - MUL: o_blk_ready=0. Right-shift GCM multiply, DIGIT bits of X per cycle:
//   - Z ^= V if X[i]; V = V>>1, ^ (0xE1<<120) if V[127]; V starts at H.
//   - After NCYC cycles: S=Z, go to ret.
//   - Handshake at cycle t -> o_blk_ready high again at t+NCYC+1.
// - Tag capture: i_tag_valid in any non-IDLE state latches i_tag and sets tag_seen.
//   - A later i_tag_valid overwrites the latched tag.
// - FIN: waits for tag_seen (may already be set). When set:
//   - o_tag = S ^ J0.
//   - o_auth_ok = (o_tag == tag), masked under the option below.
//   - Go to DONE.
// - DONE: o_done=1 for exactly one cycle, then IDLE.
// - i_start in any non-IDLE state: aborts the current message and restarts as from IDLE that cycle.
//   - o_auth_ok and o_tag are cleared to 0.
// - i_blk_valid, i_len_valid and i_tag_valid are ignored in IDLE.
// - No block count limit. Zero blocks before the length block is legal (S stays 0 for empty AAD/C).
// CONFIGURATION
// - Macro GCM_TAG_TRUNC_EN defined:
//   - Extra port i_tag_bytes (in, 5 bits) is sampled together with i_tag.
//   - Compare only the first i_tag_bytes bytes (bits [0:8*n-1]).
//   - Values outside 4..16 compare all 16 bytes.
//   - o_tag is always the full 128 bits.
// - Macro not defined: no i_tag_bytes port; full 128-bit compare.
// TESTING
// - NIST TC1 (H=66e94bd4ef8a2c3b884cfa59ca342b2e, EJ0=58e2fccefa7e3061367f1d57a4e7455a):
//   - Stimulus: start, len=0, tag=58e2fccefa7e3061367f1d57a4e7455a.
//   - Response: o_done pulse, o_auth_ok=1, o_tag=58e2...455a.
// - NIST TC2 (same H, EJ0):
//   - Stimulus: blk=0388dace60b6a392f328c2b971b2fe78, len=...0080, tag=ab6e47d42cec13bdf53a67b21257bddf.
//   - Response: o_auth_ok=1; with DIGIT=1, o_blk_ready is low for exactly 128 cycles after each handshake.
// - TC2 with tag bit 127 flipped -> o_auth_ok=0, o_tag=ab6e47d42cec13bdf53a67b21257bddf.
// - Simultaneous and early events:
//   - blk_valid and len_valid in the same ACC cycle -> only the block is consumed; len is consumed after MUL.
//   - Tag sent before the length block -> result identical to TC2.
// - Restart and reset:
//   - i_start mid-MUL, then run TC1 -> TC1 result.
//   - rst mid-MUL -> o_busy=0, o_blk_ready=0, o_tag=0, o_auth_ok=0 next cycle.
// - GCM_TAG_TRUNC_EN: TC2 with i_tag_bytes=12 and last 4 tag bytes corrupted -> o_auth_ok=1.
//   - Same stimulus with i_tag_bytes=16, or built without the macro -> o_auth_ok=0.

Source files
------------

// File: rtl/gcm_tag_verify_if.sv
// Bus bundle for gcm_tag_verify: key material, block/length stream, received tag and result.
// i_tag_bytes exists only when GCM_TAG_TRUNC_EN is defined.
interface gcm_tag_verify_if;
  logic [127:0] i_h;
  logic [127:0] i_encrypted_j0;
  logic         i_start;
  logic         i_blk_valid;
  logic [127:0] i_blk;
  logic         i_len_valid;
  logic [127:0] i_len;
  logic         o_blk_ready;
  logic         i_tag_valid;
  logic [127:0] i_tag;
`ifdef GCM_TAG_TRUNC_EN
  logic [4:0]   i_tag_bytes;
`endif
  logic         o_busy;
  logic         o_done;
  logic         o_auth_ok;
  logic [127:0] o_tag;

  modport master (
    output i_h, i_encrypted_j0, i_start, i_blk_valid, i_blk, i_len_valid, i_len,
    output i_tag_valid, i_tag,
`ifdef GCM_TAG_TRUNC_EN
    output i_tag_bytes,
`endif
    input  o_blk_ready, o_busy, o_done, o_auth_ok, o_tag
  );

  modport slave (
    input  i_h, i_encrypted_j0, i_start, i_blk_valid, i_blk, i_len_valid, i_len,
    input  i_tag_valid, i_tag,
`ifdef GCM_TAG_TRUNC_EN
    input  i_tag_bytes,
`endif
    output o_blk_ready, o_busy, o_done, o_auth_ok, o_tag
  );
endinterface

// File: rtl/gcm_tag_verify.sv
// Decrypt-side GCM tag check: GHASH over AAD/ciphertext blocks and the length block with a
// digit-serial GF(2^128) multiplier, then T = S ^ E(K,J0) compared against the received tag.
// Vectors are GCM order: GCM bit 0 (MSB) sits at vector index 127.
// Optional macro GCM_TAG_TRUNC_EN: compare only the first i_tag_bytes bytes (4..16 honoured).
module gcm_tag_verify #(
  parameter int unsigned DIGIT = 1
) (
  input logic             clk,
  input logic             rst,
  gcm_tag_verify_if.slave bus
);
  localparam int unsigned NCYC       = 128 / DIGIT;
  localparam int unsigned CW         = $clog2(NCYC + 1);
  localparam logic [127:0] R_POLY    = {8'he1, 120'd0};
  localparam logic [127:0] ALL_ONES  = '1;

  typedef enum logic [2:0] {StIdle, StAcc, StMul, StFin, StDone} state_e;

  state_e         r_state;
  state_e         w_state_d;
  logic           r_ret_fin;   // multiply was for the length block
  logic [127:0]   r_h;
  logic [127:0]   r_j0;
  logic [127:0]   r_s;
  logic [127:0]   r_x;
  logic [127:0]   r_z;
  logic [127:0]   r_v;
  logic [CW-1:0]  r_cnt;
  logic [127:0]   r_tag_rx;
  logic           r_tag_seen;
  logic [127:0]   r_tag_out;
  logic           r_auth_ok;
`ifdef GCM_TAG_TRUNC_EN
  logic [4:0]     r_tag_bytes;
`endif

  logic           w_blk_ready;
  logic           w_take_blk;
  logic           w_take_len;
  logic           w_mul_last;
  logic           w_fin;
  logic [127:0]   w_z_step;
  logic [127:0]   w_v_step;
  logic [127:0]   w_xs;
  logic [127:0]   w_tag_calc;
  logic [127:0]   w_mask;
  logic           w_match;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  // Next-state and handshake decode; i_start overrides everything outside reset.
  always_comb begin
    w_state_d   = r_state;
    w_blk_ready = (r_state == StAcc);
    w_take_blk  = 1'b0;
    w_take_len  = 1'b0;
    w_mul_last  = 1'b0;
    w_fin       = 1'b0;
    if (bus.i_start) begin
      w_state_d = StAcc;
    end else begin
      unique case (r_state)
        StIdle: w_state_d = StIdle;
        StAcc: begin
          // Block wins over length; a pending length waits for the next ACC visit.
          if (bus.i_blk_valid) begin
            w_take_blk = 1'b1;
            w_state_d  = StMul;
          end else if (bus.i_len_valid) begin
            w_take_len = 1'b1;
            w_state_d  = StMul;
          end
        end
        StMul: begin
          if (r_cnt == CW'(NCYC - 1)) begin
            w_mul_last = 1'b1;
            w_state_d  = r_ret_fin ? StFin : StAcc;
          end
        end
        StFin: begin
          if (r_tag_seen) begin
            w_fin     = 1'b1;
            w_state_d = StDone;
          end
        end
        StDone:  w_state_d = StIdle;
        default: w_state_d = StIdle;
      endcase
    end
  end

  // One multiplier digit: consume the top DIGIT bits of X, right-shift V with reduction.
  always_comb begin
    w_z_step = r_z;
    w_v_step = r_v;
    w_xs     = r_x;
    for (int unsigned k = 0; k < DIGIT; k++) begin
      if (w_xs[127]) w_z_step = w_z_step ^ w_v_step;
      w_v_step = w_v_step[0] ? ((w_v_step >> 1) ^ R_POLY) : (w_v_step >> 1);
      w_xs     = w_xs << 1;
    end
  end

  // Tag formation and (optionally truncated) comparison mask.
  always_comb begin
    w_tag_calc = r_s ^ r_j0;
    w_mask     = ALL_ONES;
`ifdef GCM_TAG_TRUNC_EN
    if (r_tag_bytes >= 5'd4 && r_tag_bytes <= 5'd16) begin
      w_mask = ~(ALL_ONES >> {r_tag_bytes, 3'b000});
    end
`endif
    w_match = (((w_tag_calc ^ r_tag_rx) & w_mask) == '0);
  end

  // Datapath: key latch, GHASH accumulator, multiplier registers, tag capture and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ret_fin   <= 1'b0;
      r_h         <= '0;
      r_j0        <= '0;
      r_s         <= '0;
      r_x         <= '0;
      r_z         <= '0;
      r_v         <= '0;
      r_cnt       <= '0;
      r_tag_rx    <= '0;
      r_tag_seen  <= 1'b0;
      r_tag_out   <= '0;
      r_auth_ok   <= 1'b0;
`ifdef GCM_TAG_TRUNC_EN
      r_tag_bytes <= '0;
`endif
    end else if (bus.i_start) begin
      r_h        <= bus.i_h;
      r_j0       <= bus.i_encrypted_j0;
      r_s        <= '0;
      r_tag_seen <= 1'b0;
      r_tag_out  <= '0;
      r_auth_ok  <= 1'b0;
    end else begin
      if (r_state != StIdle && bus.i_tag_valid) begin
        r_tag_rx    <= bus.i_tag;
        r_tag_seen  <= 1'b1;
`ifdef GCM_TAG_TRUNC_EN
        r_tag_bytes <= bus.i_tag_bytes;
`endif
      end
      if (w_take_blk || w_take_len) begin
        r_x       <= r_s ^ (w_take_blk ? bus.i_blk : bus.i_len);
        r_z       <= '0;
        r_v       <= r_h;
        r_cnt     <= '0;
        r_ret_fin <= w_take_len;
      end
      if (r_state == StMul) begin
        r_x   <= r_x << DIGIT;
        r_z   <= w_z_step;
        r_v   <= w_v_step;
        r_cnt <= r_cnt + 1'b1;
        if (w_mul_last) r_s <= w_z_step;
      end
      if (w_fin) begin
        r_tag_out <= w_tag_calc;
        r_auth_ok <= w_match;
      end
    end
  end

  assign bus.o_blk_ready = w_blk_ready;
  assign bus.o_busy      = (r_state != StIdle);
  assign bus.o_done      = (r_state == StDone);
  assign bus.o_auth_ok   = r_auth_ok;
  assign bus.o_tag       = r_tag_out;

endmodule

// File: tb/tb_gcm_tag_verify.sv
// Scoreboard bench for gcm_tag_verify: NIST vectors, corner cases and random messages
// checked against a GHASH reference model; a negedge monitor pops expectations on o_done.
module tb_gcm_tag_verify;
  localparam int unsigned DIGIT = 1;
  localparam int unsigned NCYC  = 128 / DIGIT;
  localparam int unsigned BUDGET = 2000;
  localparam logic [127:0] TC_H   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] TC_EJ0 = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] TC2_C  = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] TC2_L  = 128'h00000000000000000000000000000080;
  localparam logic [127:0] TC2_T  = 128'hab6e47d42cec13bdf53a67b21257bddf;

  typedef struct packed {
    logic [127:0] tag;
    logic         ok;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done   = 0;
  exp_t exp_q[$];
  logic [127:0] blk_list[$];

  gcm_tag_verify_if bus ();

  gcm_tag_verify #(.DIGIT(DIGIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: GF(2^128) product by the GCM definition, bit 0 = MSB.
  function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z = '0;
    logic [127:0] v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[7'(127 - i)]) z ^= v;
      v = v[0] ? ((v >> 1) ^ {8'he1, 120'd0}) : (v >> 1);
    end
    return z;
  endfunction

  function automatic logic [127:0] model_tag(input logic [127:0] h, input logic [127:0] ej0,
                                             input logic [127:0] len);
    logic [127:0] s = '0;
    foreach (blk_list[i]) s = gf_mul(s ^ blk_list[i], h);
    s = gf_mul(s ^ len, h);
    return s ^ ej0;
  endfunction

  function automatic logic model_auth(input logic [127:0] calc, input logic [127:0] rx,
                                      input logic [4:0] nb);
    int n = int'(nb);
`ifndef GCM_TAG_TRUNC_EN
    n = 16;
`endif
    if (n < 4 || n > 16) n = 16;
    for (int i = 0; i < n; i++) begin
      if (8'(calc >> (8 * (15 - i))) != 8'(rx >> (8 * (15 - i)))) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Monitor: pop and compare on every done pulse.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst === 1'b0 && bus.o_done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got o_done=1, expected no result pending");
      end else begin
        e = exp_q.pop_front();
        check("o_tag", bus.o_tag, e.tag);
        check("o_auth_ok", 128'(bus.o_auth_ok), 128'(e.ok));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_h = '0; bus.i_encrypted_j0 = '0; bus.i_start = 1'b0;
    bus.i_blk_valid = 1'b0; bus.i_blk = '0; bus.i_len_valid = 1'b0; bus.i_len = '0;
    bus.i_tag_valid = 1'b0; bus.i_tag = '0;
`ifdef GCM_TAG_TRUNC_EN
    bus.i_tag_bytes = 5'd16;
`endif
  endtask

  task automatic start_msg(input logic [127:0] h, input logic [127:0] ej0);
    bus.i_h = h; bus.i_encrypted_j0 = ej0; bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int c = 0;
    while (bus.o_blk_ready !== 1'b1 && c < BUDGET) begin tick(); c++; end
    if (bus.o_blk_ready !== 1'b1) begin
      n_checks++; n_errors++;
      $display("FAIL %s: got no o_blk_ready within %0d cycles, expected ready", name, BUDGET);
    end
  endtask

  // Cycles with ready low, measured from the cycle after a handshake edge.
  task automatic measure_low(output int low);
    low = 0;
    while (bus.o_blk_ready !== 1'b1 && low < BUDGET) begin low++; tick(); end
  endtask

  task automatic send_blk(input logic [127:0] b, output int low);
    bus.i_blk = b; bus.i_blk_valid = 1'b1;
    wait_ready("blk_wait");
    tick();
    bus.i_blk_valid = 1'b0;
    measure_low(low);
  endtask

  task automatic send_len(input logic [127:0] l);
    bus.i_len = l; bus.i_len_valid = 1'b1;
    wait_ready("len_wait");
    tick();
    bus.i_len_valid = 1'b0;
  endtask

  task automatic send_tag(input logic [127:0] t, input logic [4:0] nb);
    bus.i_tag = t; bus.i_tag_valid = 1'b1;
`ifdef GCM_TAG_TRUNC_EN
    bus.i_tag_bytes = nb;
`endif
    tick();
    bus.i_tag_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int c = 0;
    int d0 = n_done;
    while (n_done == d0 && c < BUDGET) begin tick(); c++; end
    if (n_done == d0) begin
      n_checks++; n_errors++;
      $display("FAIL %s_done: got no o_done within %0d cycles, expected a pulse", name, BUDGET);
    end else begin
      check({name, "_done_pulse"}, 128'(bus.o_done), 128'd0);
      check({name, "_busy_after"}, 128'(bus.o_busy), 128'd0);
    end
  endtask

  task automatic run_msg(input string name, input logic [127:0] h, input logic [127:0] ej0,
                         input logic [127:0] len, input logic [127:0] tag, input logic [4:0] nb,
                         input bit tag_early);
    logic [127:0] t;
    int low;
    t = model_tag(h, ej0, len);
    exp_q.push_back('{tag: t, ok: model_auth(t, tag, nb)});
    start_msg(h, ej0);
    if (tag_early) send_tag(tag, nb);
    foreach (blk_list[i]) begin
      send_blk(blk_list[i], low);
      check({name, "_ready_low"}, 128'(low), 128'(NCYC));
    end
    send_len(len);
    if (!tag_early) send_tag(tag, nb);
    wait_done(name);
  endtask

  initial begin
    int low;
    idle_inputs();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check("rst_busy", 128'(bus.o_busy), 128'd0);
    check("rst_ready", 128'(bus.o_blk_ready), 128'd0);
    check("rst_done", 128'(bus.o_done), 128'd0);
    check("rst_auth", 128'(bus.o_auth_ok), 128'd0);
    check("rst_tag", bus.o_tag, 128'd0);

    // Block/tag strobes in IDLE must not wake the core.
    bus.i_blk_valid = 1'b1; bus.i_tag_valid = 1'b1; bus.i_len_valid = 1'b1;
    tick(2);
    idle_inputs();
    check("idle_ignore_busy", 128'(bus.o_busy), 128'd0);

    blk_list.delete();
    run_msg("tc1", TC_H, TC_EJ0, '0, TC_EJ0, 5'd16, 1'b0);
    check("tc1_tag_hold", bus.o_tag, TC_EJ0);

    blk_list.delete(); blk_list.push_back(TC2_C);
    run_msg("tc2", TC_H, TC_EJ0, TC2_L, TC2_T, 5'd16, 1'b0);
    run_msg("tc2_bad", TC_H, TC_EJ0, TC2_L, TC2_T ^ 128'h1, 5'd16, 1'b0);
    run_msg("tc2_early", TC_H, TC_EJ0, TC2_L, TC2_T, 5'd16, 1'b1);

    // Truncated compare: last four bytes corrupted.
    run_msg("trunc12", TC_H, TC_EJ0, TC2_L, TC2_T ^ 128'hdeadbeef, 5'd12, 1'b0);
    run_msg("trunc16", TC_H, TC_EJ0, TC2_L, TC2_T ^ 128'hdeadbeef, 5'd16, 1'b0);

    // Block and length offered together: only the block goes first.
    exp_q.push_back('{tag: TC2_T, ok: 1'b1});
    start_msg(TC_H, TC_EJ0);
    bus.i_blk = TC2_C; bus.i_blk_valid = 1'b1;
    bus.i_len = TC2_L; bus.i_len_valid = 1'b1;
    wait_ready("simul_wait");
    tick();
    bus.i_blk_valid = 1'b0;
    measure_low(low);
    check("simul_ready_low", 128'(low), 128'(NCYC));
    tick();
    bus.i_len_valid = 1'b0;
    send_tag(TC2_T, 5'd16);
    wait_done("simul");

    // i_start after a finished message clears results; then abort mid-MUL and run TC1.
    start_msg({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    check("start_clr_tag", bus.o_tag, 128'd0);
    check("start_clr_auth", 128'(bus.o_auth_ok), 128'd0);
    check("start_busy", 128'(bus.o_busy), 128'd1);
    bus.i_blk = {$urandom, $urandom, $urandom, $urandom}; bus.i_blk_valid = 1'b1;
    wait_ready("abort_wait");
    tick();
    bus.i_blk_valid = 1'b0;
    tick(20);
    blk_list.delete();
    run_msg("restart_tc1", TC_H, TC_EJ0, '0, TC_EJ0, 5'd16, 1'b0);

    // Reset in the middle of a multiply.
    start_msg(TC_H, TC_EJ0);
    bus.i_blk = TC2_C; bus.i_blk_valid = 1'b1;
    wait_ready("rst_mul_wait");
    tick();
    bus.i_blk_valid = 1'b0;
    tick(10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmul_busy", 128'(bus.o_busy), 128'd0);
    check("rstmul_ready", 128'(bus.o_blk_ready), 128'd0);
    check("rstmul_tag", bus.o_tag, 128'd0);
    check("rstmul_auth", 128'(bus.o_auth_ok), 128'd0);

    // Random messages.
    for (int m = 0; m < 20; m++) begin
      logic [127:0] h, ej0, len, tag, good;
      logic [4:0] nb;
      int nblk;
      h = {$urandom, $urandom, $urandom, $urandom};
      ej0 = {$urandom, $urandom, $urandom, $urandom};
      len = {$urandom, $urandom, $urandom, $urandom};
      nblk = int'($urandom_range(0, 3));
      blk_list.delete();
      for (int b = 0; b < nblk; b++) blk_list.push_back({$urandom, $urandom, $urandom, $urandom});
      good = model_tag(h, ej0, len);
      tag = good;
      if ($urandom_range(0, 1) == 1) tag = good ^ (128'h1 << $urandom_range(0, 127));
      nb = 5'($urandom_range(0, 31));
      run_msg("rand", h, ej0, len, tag, nb, $urandom_range(0, 1) == 1);
    end

    check("scoreboard_drain", 128'(exp_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion by time limit, expected $finish");
    $fatal(1);
  end

endmodule
